irrigation_sequencer: RTL and testbench
=======================================

Name: irrigation_sequencer

Overview:
Clocked controller that sequences the greenhouse water system: tank fill valve, sprinkler pump and dripper valve. It debounces the six field sensors and latches water-level sensor faults. It enforces mutual exclusion between sprinkler and dripper, plus minimum run, maximum run and cooldown times. It sits between the raw sensor pins and the actuator outputs and replaces the purely combinational decision path.

Parameters:
DEBOUNCE_TICKS, 3, consecutive ticks a raw sensor must differ from its filtered value before the filtered value flips
MIN_ON_TICKS, 10, minimum irrigation run once started, unless water is lost
MAX_ON_TICKS, 60, hard cap on one irrigation run; must be >= MIN_ON_TICKS
COOLDOWN_TICKS, 20, mandatory rest after any run or fault clear
FILL_TIMEOUT_TICKS, 120, fill-valve open time that declares a fault (optional feature only)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
tick  in  1  single-cycle time-base strobe; all timers advance only on tick
low_watter_level  in  1  raw tank sensor, 1 = water at low mark
mid_watter_level  in  1  raw tank sensor, 1 = water at mid mark
high_watter_level  in  1  raw tank sensor, 1 = water at high mark
earth_humidity  in  1  raw, 1 = soil wet
air_humidity  in  1  raw, 1 = air humid
low_temperature  in  1  raw, 1 = cold
alarm_clear  in  1  level; operator acknowledge of a latched fault
watter_supply_valvule  out  1  tank fill valve
splinker_bomb  out  1  sprinkler pump
dripper_valvule  out  1  dripper valve
alarm  out  1  latched fault indicator
fault_cause  out  2  0 none, 1 level-sensor inconsistency, 2 fill timeout
state  out  3  current FSM state code

Behaviour:
- Reset (synchronous): state IDLE (0). All outputs 0, fault_cause 0, all counters 0, all filtered sensors 0.
- Debounce: per sensor, count consecutive ticks where raw != filtered. Reaching DEBOUNCE_TICKS flips filtered and clears the count. Any tick where raw == filtered clears the count. All decisions below use filtered values.
- Level check, combinational on filtered values: inconsistent = (high & ~mid) | (mid & ~low). When true, alarm=1 and fault_cause=1 on the next edge; state goes to FAULT on the same edge.
- Fill valve: watter_supply_valvule = ~high & (state != FAULT), registered, so one cycle of latency. After reset it rises on the second cycle because filtered high = 0.
- Demand: dry = ~earth_humidity. sprinkle_ok = mid & ~air_humidity & ~low_temperature. drip_ok = low.
- FSM codes: IDLE=0, SPRINKLING=1, DRIPPING=2, COOLDOWN=3, FAULT=4.
- IDLE:
  - dry & sprinkle_ok -> SPRINKLING.
  - else dry & drip_ok -> DRIPPING.
  - else stay.
- SPRINKLING / DRIPPING:
  - run counter clears on entry and increments on tick, saturating at MAX_ON_TICKS.
  - Exit to COOLDOWN when any of: (earth wet & run >= MIN_ON_TICKS); run == MAX_ON_TICKS; source lost (~mid for SPRINKLING, ~low for DRIPPING). Source loss overrides MIN_ON_TICKS.
  - The two modes never switch directly into each other.
- COOLDOWN: counts COOLDOWN_TICKS ticks, then -> IDLE.
- FAULT: splinker_bomb, dripper_valvule and the fill valve are 0. alarm holds. alarm_clear=1 while inconsistent=0 -> COOLDOWN, with alarm and fault_cause cleared on the same edge. alarm_clear while still inconsistent is ignored.
- Outputs are registered from state: splinker_bomb = (state==SPRINKLING), dripper_valvule = (state==DRIPPING). They are never 1 simultaneously.
- Fault priority: a fault in any state preempts on the next edge. Sensor cause wins over timeout if both occur in the same cycle.
- Reset asserted mid-run: all outputs drop on that edge; no cooldown is enforced.
- Counter widths are $clog2(max parameter + 1). Tick is ignored while reset = 1.

Optional Feature:
- Macro: IRRIGATION_FILL_TIMEOUT_EN.
- Defined: a fill counter increments on tick while the fill valve is 1 and clears when the valve is 0. Reaching FILL_TIMEOUT_TICKS -> FAULT with fault_cause=2; clearing follows the FAULT rules above.
- Undefined: no fill counter; fault_cause never takes the value 2; FILL_TIMEOUT_TICKS is unused.

Decomposition:
- Package irrigation_pkg holds the state codes, the fault_cause codes and the state width.
- One sub-module, sensor_debouncer (parameter DEBOUNCE_TICKS; ports clk, reset, tick, raw, filtered), instantiated six times.

Test Plan:
All tests use DEBOUNCE=2, MIN=3, MAX=6, COOL=2, FILL=5, with tick every cycle.
- Reset then low=mid=high=0 -> fill valve 1 on cycle 2. Raise all three for 2 ticks -> fill valve 0 one cycle after filtered high=1.
- Levels all 1, earth dry, air dry, warm -> SPRINKLING. Earth goes wet at run=1 -> stays until run=3, then COOLDOWN for 2 ticks, then IDLE.
- Levels all 1, earth dry, cold -> DRIPPING. Earth stays dry -> exits at run=6 to COOLDOWN.
- During SPRINKLING, drop mid for 2 ticks -> COOLDOWN immediately, ignoring MIN_ON.
- Force high=1, mid=0 -> alarm=1, fault_cause=1, all actuators 0. alarm_clear while still inconsistent -> no change. Fix levels then alarm_clear -> COOLDOWN, alarm=0.
- With IRRIGATION_FILL_TIMEOUT_EN, hold high=0 -> fault_cause=2 after 5 ticks of valve open. Assert reset mid-run -> all outputs 0 and state 0 on that edge.

Source files
------------

// File: rtl/irrigation_pkg.sv
// irrigation_pkg: FSM state codes, fault cause codes and state width for the irrigation sequencer
package irrigation_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE       = 3'd0,
        ST_SPRINKLING = 3'd1,
        ST_DRIPPING   = 3'd2,
        ST_COOLDOWN   = 3'd3,
        ST_FAULT      = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_LEVEL   = 2'd1,
        CAUSE_TIMEOUT = 2'd2
    } cause_t;

endpackage

// File: rtl/sensor_debouncer.sv
// sensor_debouncer: flips the filtered level after DEBOUNCE_TICKS consecutive ticks of disagreement
module sensor_debouncer #(
    parameter int DEBOUNCE_TICKS = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw,
    output logic filtered
);

    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

    logic [CW-1:0] r_cnt;
    logic          r_filt;

    // count disagreeing ticks; any agreeing tick restarts the count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else if (tick) begin
            if (raw == r_filt) begin
                r_cnt <= '0;
            end else if (int'(r_cnt) + 1 >= DEBOUNCE_TICKS) begin
                r_filt <= raw;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign filtered = r_filt;

endmodule

// File: rtl/irrigation_sequencer.sv
// irrigation_sequencer: debounced greenhouse water sequencer (fill valve, sprinkler, dripper) with fault latch.
// Optional fill-valve timeout fault enabled by defining IRRIGATION_FILL_TIMEOUT_EN.
module irrigation_sequencer
    import irrigation_pkg::*;
#(
    parameter int DEBOUNCE_TICKS     = 3,
    parameter int MIN_ON_TICKS       = 10,
    parameter int MAX_ON_TICKS       = 60,
    parameter int COOLDOWN_TICKS     = 20,
    parameter int FILL_TIMEOUT_TICKS = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       low_watter_level,
    input  logic       mid_watter_level,
    input  logic       high_watter_level,
    input  logic       earth_humidity,
    input  logic       air_humidity,
    input  logic       low_temperature,
    input  logic       alarm_clear,
    output logic       watter_supply_valvule,
    output logic       splinker_bomb,
    output logic       dripper_valvule,
    output logic       alarm,
    output logic [1:0] fault_cause,
    output logic [2:0] state
);

    localparam int T_TOP = (MAX_ON_TICKS > COOLDOWN_TICKS) ? MAX_ON_TICKS : COOLDOWN_TICKS;
    localparam int TW    = $clog2(T_TOP + 1);
    localparam logic [TW-1:0] T_SAT = TW'(T_TOP);

    localparam int S_LOW   = 0;
    localparam int S_MID   = 1;
    localparam int S_HIGH  = 2;
    localparam int S_EARTH = 3;
    localparam int S_AIR   = 4;
    localparam int S_COLD  = 5;

    logic [5:0] w_raw;
    logic [5:0] w_filt;

    assign w_raw = {low_temperature, air_humidity, earth_humidity,
                    high_watter_level, mid_watter_level, low_watter_level};

    for (genvar g = 0; g < 6; g++) begin : g_deb
        sensor_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb (
            .clk      (clk),
            .reset    (reset),
            .tick     (tick),
            .raw      (w_raw[g]),
            .filtered (w_filt[g])
        );
    end

    logic w_low, w_mid, w_high, w_wet, w_air, w_cold;

    assign w_low  = w_filt[S_LOW];
    assign w_mid  = w_filt[S_MID];
    assign w_high = w_filt[S_HIGH];
    assign w_wet  = w_filt[S_EARTH];
    assign w_air  = w_filt[S_AIR];
    assign w_cold = w_filt[S_COLD];

    state_t        r_state;
    cause_t        r_cause;
    logic [TW-1:0] r_timer;
    logic          r_fill;
    logic          r_spr;
    logic          r_drip;
    logic          r_alarm;

    logic w_inconsistent, w_dry, w_sprinkle_ok, w_drip_ok, w_run_done, w_cool_done, w_timeout;

    assign w_inconsistent = (w_high & ~w_mid) | (w_mid & ~w_low);
    assign w_dry          = ~w_wet;
    assign w_sprinkle_ok  = w_mid & ~w_air & ~w_cold;
    assign w_drip_ok      = w_low;
    assign w_run_done     = (w_wet && int'(r_timer) >= MIN_ON_TICKS) || (int'(r_timer) == MAX_ON_TICKS);
    assign w_cool_done    = tick && (int'(r_timer) + 1 >= COOLDOWN_TICKS);

`ifdef IRRIGATION_FILL_TIMEOUT_EN
    localparam int FW = $clog2(FILL_TIMEOUT_TICKS + 1);

    logic [FW-1:0] r_fill_cnt;

    // time how long the fill valve has been open, saturating at the timeout
    always_ff @(posedge clk) begin
        if (reset || !r_fill) begin
            r_fill_cnt <= '0;
        end else if (tick && int'(r_fill_cnt) < FILL_TIMEOUT_TICKS) begin
            r_fill_cnt <= r_fill_cnt + 1'b1;
        end
    end

    assign w_timeout = int'(r_fill_cnt) >= FILL_TIMEOUT_TICKS;
`else
    assign w_timeout = (FILL_TIMEOUT_TICKS < 0);
`endif

    state_t w_next;
    cause_t w_cause;

    // next state: level fault beats fill timeout, both preempt every state
    always_comb begin
        w_next  = r_state;
        w_cause = r_cause;
        if (w_inconsistent) begin
            w_next  = ST_FAULT;
            w_cause = CAUSE_LEVEL;
        end else if (w_timeout && r_state != ST_FAULT) begin
            w_next  = ST_FAULT;
            w_cause = CAUSE_TIMEOUT;
        end else begin
            case (r_state)
                ST_IDLE:       w_next = (w_dry && w_sprinkle_ok) ? ST_SPRINKLING :
                                        (w_dry && w_drip_ok)     ? ST_DRIPPING   : ST_IDLE;
                ST_SPRINKLING: w_next = (!w_mid || w_run_done) ? ST_COOLDOWN : ST_SPRINKLING;
                ST_DRIPPING:   w_next = (!w_low || w_run_done) ? ST_COOLDOWN : ST_DRIPPING;
                ST_COOLDOWN:   w_next = w_cool_done ? ST_IDLE : ST_COOLDOWN;
                ST_FAULT:      w_next = alarm_clear ? ST_COOLDOWN : ST_FAULT;
                default:       w_next = ST_IDLE;
            endcase
        end
    end

    // state, shared run/cooldown timer and actuator outputs registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cause <= CAUSE_NONE;
            r_timer <= '0;
            r_fill  <= 1'b0;
            r_spr   <= 1'b0;
            r_drip  <= 1'b0;
            r_alarm <= 1'b0;
        end else begin
            r_state <= w_next;
            r_timer <= (w_next != r_state) ? '0 :
                       (tick && r_timer != T_SAT) ? r_timer + 1'b1 : r_timer;
            r_fill  <= ~w_high & (w_next != ST_FAULT);
            r_spr   <= (w_next == ST_SPRINKLING);
            r_drip  <= (w_next == ST_DRIPPING);
            r_alarm <= (w_next == ST_FAULT);
            r_cause <= (w_next == ST_FAULT) ? w_cause : CAUSE_NONE;
        end
    end

    assign watter_supply_valvule = r_fill;
    assign splinker_bomb         = r_spr;
    assign dripper_valvule       = r_drip;
    assign alarm                 = r_alarm;
    assign fault_cause           = r_cause;
    assign state                 = r_state;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// tb_irrigation_sequencer: directed scenarios with a queued scoreboard checked by an independent monitor
module tb_irrigation_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b1;
    logic       low = 1'b0, mid = 1'b0, high = 1'b0;
    logic       earth = 1'b0, air = 1'b0, cold = 1'b0;
    logic       alarm_clear = 1'b0;
    logic       fill, spr, drip, alarm;
    logic [1:0] cause;
    logic [2:0] st;

    irrigation_sequencer #(
        .DEBOUNCE_TICKS     (2),
        .MIN_ON_TICKS       (3),
        .MAX_ON_TICKS       (6),
        .COOLDOWN_TICKS     (2),
        .FILL_TIMEOUT_TICKS (5)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .tick                  (tick),
        .low_watter_level      (low),
        .mid_watter_level      (mid),
        .high_watter_level     (high),
        .earth_humidity        (earth),
        .air_humidity          (air),
        .low_temperature       (cold),
        .alarm_clear           (alarm_clear),
        .watter_supply_valvule (fill),
        .splinker_bomb         (spr),
        .dripper_valvule       (drip),
        .alarm                 (alarm),
        .fault_cause           (cause),
        .state                 (st)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [8:0] exp;
    } exp_t;

    exp_t       q[$];
    exp_t       m_e;
    logic [8:0] w_act;
    int         n_checks = 0;
    int         n_fail = 0;

    assign w_act = {st, fill, spr, drip, alarm, cause};

    task automatic chk(input string n, input logic [2:0] s, input logic f, input logic sp,
                       input logic dr, input logic al, input logic [1:0] c);
        q.push_back('{n, {s, f, sp, dr, al, c}});
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            m_e = q.pop_front();
            n_checks++;
            if (w_act !== m_e.exp) begin
                n_fail++;
                $display("FAIL %s: got state=%0d fill=%b spr=%b drip=%b alarm=%b cause=%0d, expected state=%0d fill=%b spr=%b drip=%b alarm=%b cause=%0d",
                         m_e.name, w_act[8:6], w_act[5], w_act[4], w_act[3], w_act[2], w_act[1:0],
                         m_e.exp[8:6], m_e.exp[5], m_e.exp[4], m_e.exp[3], m_e.exp[2], m_e.exp[1:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        // reset and fill valve
        cyc(1);
        chk("reset", 3'd0, 0, 0, 0, 0, 2'd0);
        reset = 1'b0;
        cyc(1);
        chk("fill_rise", 3'd0, 1, 0, 0, 0, 2'd0);
        low = 1; mid = 1; high = 1; earth = 1;
        cyc(2);
        chk("fill_hold_until_filtered", 3'd0, 1, 0, 0, 0, 2'd0);
        cyc(1);
        chk("fill_off", 3'd0, 0, 0, 0, 0, 2'd0);
        // sprinkling held to MIN_ON after earth turns wet
        earth = 0;
        cyc(3);
        chk("spr_start", 3'd1, 0, 1, 0, 0, 2'd0);
        earth = 1;
        cyc(3);
        chk("spr_min_hold", 3'd1, 0, 1, 0, 0, 2'd0);
        cyc(1);
        chk("spr_to_cool", 3'd3, 0, 0, 0, 0, 2'd0);
        cyc(1);
        chk("cool_hold", 3'd3, 0, 0, 0, 0, 2'd0);
        cyc(1);
        chk("cool_to_idle", 3'd0, 0, 0, 0, 0, 2'd0);
        // dripping runs to MAX_ON
        cold = 1; earth = 0;
        cyc(3);
        chk("drip_start", 3'd2, 0, 0, 1, 0, 2'd0);
        cyc(6);
        chk("drip_at_max", 3'd2, 0, 0, 1, 0, 2'd0);
        cyc(1);
        chk("drip_max_exit", 3'd3, 0, 0, 0, 0, 2'd0);
        earth = 1; cold = 0;
        cyc(2);
        chk("drip_cool_idle", 3'd0, 0, 0, 0, 0, 2'd0);
        // source loss overrides MIN_ON
        earth = 0;
        cyc(3);
        chk("spr2_start", 3'd1, 0, 1, 0, 0, 2'd0);
        mid = 0; high = 0;
        cyc(2);
        chk("src_drop_pending", 3'd1, 0, 1, 0, 0, 2'd0);
        cyc(1);
        chk("src_lost_cool", 3'd3, 1, 0, 0, 0, 2'd0);
        mid = 1; high = 1; earth = 1;
        cyc(2);
        chk("src_cool_idle", 3'd0, 1, 0, 0, 0, 2'd0);
        cyc(1);
        chk("refill_off", 3'd0, 0, 0, 0, 0, 2'd0);
        // level sensor inconsistency fault
        mid = 0;
        cyc(3);
        chk("fault_set", 3'd4, 0, 0, 0, 1, 2'd1);
        alarm_clear = 1;
        cyc(1);
        chk("clear_ignored", 3'd4, 0, 0, 0, 1, 2'd1);
        alarm_clear = 0; mid = 1;
        cyc(2);
        chk("fault_hold", 3'd4, 0, 0, 0, 1, 2'd1);
        alarm_clear = 1;
        cyc(1);
        chk("fault_clear", 3'd3, 0, 0, 0, 0, 2'd0);
        alarm_clear = 0;
        cyc(2);
        chk("post_fault_idle", 3'd0, 0, 0, 0, 0, 2'd0);
        // long fill
        high = 0;
        cyc(3);
        chk("fill_open", 3'd0, 1, 0, 0, 0, 2'd0);
        cyc(5);
        chk("fill_run", 3'd0, 1, 0, 0, 0, 2'd0);
        cyc(1);
`ifdef IRRIGATION_FILL_TIMEOUT_EN
        chk("fill_timeout", 3'd4, 0, 0, 0, 1, 2'd2);
        alarm_clear = 1;
        cyc(1);
        chk("timeout_clear", 3'd3, 1, 0, 0, 0, 2'd0);
        alarm_clear = 0;
`else
        chk("no_fill_timeout", 3'd0, 1, 0, 0, 0, 2'd0);
`endif
        // reset in the middle of a run
        reset = 1; high = 1; earth = 0;
        cyc(1);
        chk("reset2", 3'd0, 0, 0, 0, 0, 2'd0);
        reset = 0;
        cyc(3);
        chk("spr3_start", 3'd1, 0, 1, 0, 0, 2'd0);
        cyc(1);
        reset = 1;
        cyc(1);
        chk("reset_midrun", 3'd0, 0, 0, 0, 0, 2'd0);
        reset = 0;
        cyc(1);
        chk("no_cool_after_reset", 3'd0, 1, 0, 0, 0, 2'd0);
        cyc(2);
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
